// File: rtl/score_packet_rx_pkg.sv
// score_packet_rx_pkg
// Shared definitions for the inter-board score link.
//   rx_state_t    : receive FSM states
//   IDLE_BYTE_LO/HI : filler bytes sent while the link idles; never start a frame
//   FRAME_BYTES   : bytes per frame (ID + 3 points bytes), shared with the packer
//   POINTS_W      : width of the points field carried by a frame
//   is_filler()   : true for bytes that must be skipped while hunting for a frame
package score_packet_rx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GET_B1 = 2'd1,
        GET_B2 = 2'd2,
        GET_B3 = 2'd3
    } rx_state_t;

    localparam logic [7:0] IDLE_BYTE_LO = 8'h00;
    localparam logic [7:0] IDLE_BYTE_HI = 8'hFF;

    localparam int FRAME_BYTES = 4;
    localparam int POINTS_W    = (FRAME_BYTES - 1) * 8;

    function automatic logic is_filler(input logic [7:0] b);
        return (b == IDLE_BYTE_LO) || (b == IDLE_BYTE_HI);
    endfunction

endpackage

// File: rtl/score_packet_rx_if.sv
// score_packet_rx_if
// Bundles the byte stream from the UART receiver and the decoded opponent
// score presented to game/display logic.
//   own_ID     : this board's ID (frames with it are echoes)
//   rx_done    : one-cycle byte strobe, rx_data valid with it
//   rx_data    : received byte
//   rx_err     : one-cycle UART framing-error strobe
//   opp_ID     : ID of the last accepted frame
//   opp_points : points of the last accepted frame
//   opp_valid  : one-cycle pulse when opp_ID/opp_points update
//   frame_err  : one-cycle pulse when a partial frame is aborted
//   link_up    : high while good frames keep arriving
// master = byte source / score consumer, slave = score_packet_rx.
interface score_packet_rx_if;
    import score_packet_rx_pkg::*;

    logic [7:0]          own_ID;
    logic                rx_done;
    logic [7:0]          rx_data;
    logic                rx_err;
    logic [7:0]          opp_ID;
    logic [POINTS_W-1:0] opp_points;
    logic                opp_valid;
    logic                frame_err;
    logic                link_up;

    modport master (
        output own_ID, rx_done, rx_data, rx_err,
        input  opp_ID, opp_points, opp_valid, frame_err, link_up
    );

    modport slave (
        input  own_ID, rx_done, rx_data, rx_err,
        output opp_ID, opp_points, opp_valid, frame_err, link_up
    );

endinterface

// File: rtl/score_packet_rx_timeout_counter.sv
// score_packet_rx_timeout_counter
// Cycle counter with synchronous clear. tc is high while the count sits at
// LIMIT-1, i.e. during the LIMIT-th cycle after the last clear. With SATURATE
// the count parks there (tc stays high); otherwise it wraps to zero.
//   clk, rst : clock, synchronous active-high reset
//   clear    : restart the count from zero
//   enable   : advance the count this cycle
//   tc       : terminal count reached
module score_packet_rx_timeout_counter #(
    parameter int LIMIT    = 16,
    parameter bit SATURATE = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tc
);
    localparam int CW = (LIMIT > 2) ? $clog2(LIMIT) : 1;
    localparam logic [CW-1:0] TERM = CW'(LIMIT - 1);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_reg <= '0;
        end else if (enable) begin
            if (count_reg == TERM) begin
                count_reg <= SATURATE ? TERM : '0;
            end else begin
                count_reg <= count_reg + 1'b1;
            end
        end
    end

    assign tc = (count_reg == TERM);

endmodule

// File: rtl/score_packet_rx.sv
// score_packet_rx
// Reassembles 4-byte score frames (ID, points[23:16], points[15:8],
// points[7:0]) from the UART byte stream and presents the opponent's ID and
// score. Echoes of our own ID are dropped, stalled partial frames and UART
// framing errors abort with a frame_err pulse, and link_up tracks whether
// good frames keep arriving.
//   clk, rst : clock, synchronous active-high reset
//   bus      : score_packet_rx_if.slave (byte input, score outputs)
module score_packet_rx
    import score_packet_rx_pkg::*;
#(
    parameter int BYTE_TIMEOUT = 100_000,
    parameter int LINK_TIMEOUT = 50_000_000
) (
    input  logic               clk,
    input  logic               rst,
    score_packet_rx_if.slave   bus
);

    rx_state_t           state_reg;
    logic [7:0]          id_cand_reg;
    logic [7:0]          b1_reg;
    logic [7:0]          b2_reg;
    logic [7:0]          opp_id_reg;
    logic [POINTS_W-1:0] opp_points_reg;
    logic                opp_valid_reg;
    logic                frame_err_reg;
    logic                link_up_reg;

    logic byte_tc;
    logic link_tc;
    logic byte_ok;
    logic accept;

    // A byte is only usable when no framing error arrives with it.
    assign byte_ok = bus.rx_done && !bus.rx_err;

    // Final byte of a frame from another board: load outputs next edge.
    assign accept = (state_reg == GET_B3) && byte_ok && (id_cand_reg != bus.own_ID);

    // Inter-byte timer: held at zero while hunting for a frame and
    // restarted by every byte, so it only measures stalls inside a frame.
    score_packet_rx_timeout_counter #(
        .LIMIT    (BYTE_TIMEOUT),
        .SATURATE (1'b0)
    ) u_byte_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  ((state_reg == IDLE) || bus.rx_done || bus.rx_err),
        .enable (1'b1),
        .tc     (byte_tc)
    );

    // Link timer: restarted by each accepted frame, parks at its limit.
    score_packet_rx_timeout_counter #(
        .LIMIT    (LINK_TIMEOUT),
        .SATURATE (1'b1)
    ) u_link_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (accept),
        .enable (1'b1),
        .tc     (link_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            id_cand_reg    <= '0;
            b1_reg         <= '0;
            b2_reg         <= '0;
            opp_id_reg     <= '0;
            opp_points_reg <= '0;
            opp_valid_reg  <= 1'b0;
            frame_err_reg  <= 1'b0;
            link_up_reg    <= 1'b0;
        end else begin
            opp_valid_reg <= 1'b0;
            frame_err_reg <= 1'b0;

            if (accept) begin
                link_up_reg <= 1'b1;
            end else if (link_tc) begin
                link_up_reg <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    // Filler bytes and errored bytes never open a frame.
                    if (byte_ok && !is_filler(bus.rx_data)) begin
                        id_cand_reg <= bus.rx_data;
                        state_reg   <= GET_B1;
                    end
                end
                GET_B1, GET_B2, GET_B3: begin
                    // Priority: framing error, then a fresh byte (which
                    // beats a simultaneous timeout), then the timeout.
                    if (bus.rx_err) begin
                        frame_err_reg <= 1'b1;
                        state_reg     <= IDLE;
                    end else if (bus.rx_done) begin
                        case (state_reg)
                            GET_B1: begin
                                b1_reg    <= bus.rx_data;
                                state_reg <= GET_B2;
                            end
                            GET_B2: begin
                                b2_reg    <= bus.rx_data;
                                state_reg <= GET_B3;
                            end
                            default: begin
                                state_reg <= IDLE;
                                if (accept) begin
                                    opp_id_reg     <= id_cand_reg;
                                    opp_points_reg <= {b1_reg, b2_reg, bus.rx_data};
                                    opp_valid_reg  <= 1'b1;
                                end
                            end
                        endcase
                    end else if (byte_tc) begin
                        frame_err_reg <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.opp_ID     = opp_id_reg;
    assign bus.opp_points = opp_points_reg;
    assign bus.opp_valid  = opp_valid_reg;
    assign bus.frame_err  = frame_err_reg;
    assign bus.link_up    = link_up_reg;

endmodule

// File: tb/tb_score_packet_rx.sv
// tb_score_packet_rx
// Directed bench for score_packet_rx with BYTE_TIMEOUT=16, LINK_TIMEOUT=100.
// Inputs change 1 time unit after the rising edge; outputs are checked at
// the same point, so a value seen right after a byte's edge is what the DUT
// registered on that edge.
module tb_score_packet_rx;
    import score_packet_rx_pkg::*;

    localparam int BT = 16;
    localparam int LT = 100;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks = 0;
    int errors = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int fe_snap;
    int ov_snap;

    score_packet_rx_if bus ();

    score_packet_rx #(
        .BYTE_TIMEOUT (BT),
        .LINK_TIMEOUT (LT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.frame_err) fe_cnt++;
        if (bus.opp_valid) ov_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data = b;
        bus.rx_done = 1'b1;
        tick();
        bus.rx_done = 1'b0;
        bus.rx_data = 8'h00;
        $display("t=%0t rx byte %02h -> opp_valid=%0b frame_err=%0b opp_ID=%02h opp_points=%06h link_up=%0b",
                 $time, b, bus.opp_valid, bus.frame_err, bus.opp_ID, bus.opp_points, bus.link_up);
    endtask

    task automatic send_frame(input logic [7:0] id, input logic [7:0] p2,
                              input logic [7:0] p1, input logic [7:0] p0);
        send_byte(id);
        send_byte(p2);
        send_byte(p1);
        send_byte(p0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.own_ID  = 8'h01;
        bus.rx_done = 1'b0;
        bus.rx_data = 8'h00;
        bus.rx_err  = 1'b0;
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        tick();
        check("reset_opp_ID", 32'(bus.opp_ID), 32'h0);
        check("reset_opp_points", 32'(bus.opp_points), 32'h0);
        check("reset_opp_valid", 32'(bus.opp_valid), 32'h0);
        check("reset_frame_err", 32'(bus.frame_err), 32'h0);
        check("reset_link_up", 32'(bus.link_up), 32'h0);

        // Frame with 10-cycle byte spacing.
        send_byte(8'h02); idle(9);
        send_byte(8'h12); idle(9);
        send_byte(8'h34); idle(9);
        send_byte(8'h56);
        check("f1_opp_valid", 32'(bus.opp_valid), 32'h1);
        check("f1_opp_ID", 32'(bus.opp_ID), 32'h02);
        check("f1_opp_points", 32'(bus.opp_points), 32'h123456);
        check("f1_link_up", 32'(bus.link_up), 32'h1);
        tick();
        check("f1_valid_one_cycle", 32'(bus.opp_valid), 32'h0);
        check("f1_hold_ID", 32'(bus.opp_ID), 32'h02);

        // Echo of own ID: dropped, outputs hold.
        send_frame(8'h01, 8'hAA, 8'hBB, 8'hCC);
        check("echo_no_valid", 32'(bus.opp_valid), 32'h0);
        check("echo_hold_ID", 32'(bus.opp_ID), 32'h02);
        check("echo_hold_points", 32'(bus.opp_points), 32'h123456);
        tick();
        check("echo_valid_count", 32'(ov_cnt), 32'd1);

        // Fillers ahead of a frame; data bytes of 00 are real data.
        fe_snap = fe_cnt;
        send_byte(8'hFF);
        send_byte(8'h00);
        send_frame(8'h03, 8'h00, 8'h00, 8'h07);
        check("fill_opp_valid", 32'(bus.opp_valid), 32'h1);
        check("fill_opp_ID", 32'(bus.opp_ID), 32'h03);
        check("fill_opp_points", 32'(bus.opp_points), 32'h000007);
        tick();
        check("fill_no_frame_err", 32'(fe_cnt), 32'(fe_snap));

        // Byte timeout: expiry on the 16th cycle after the last byte.
        send_byte(8'h02);
        send_byte(8'h11);
        idle(15);
        check("bto_before_expiry", 32'(bus.frame_err), 32'h0);
        tick();
        check("bto_frame_err", 32'(bus.frame_err), 32'h1);
        check("bto_no_valid", 32'(bus.opp_valid), 32'h0);
        tick();
        check("bto_pulse_one_cycle", 32'(bus.frame_err), 32'h0);
        idle(3);
        send_frame(8'h02, 8'hAB, 8'hCD, 8'hEF);
        check("bto_next_valid", 32'(bus.opp_valid), 32'h1);
        check("bto_next_ID", 32'(bus.opp_ID), 32'h02);
        check("bto_next_points", 32'(bus.opp_points), 32'hABCDEF);

        // rx_err together with rx_done: error wins, byte discarded.
        send_byte(8'h02);
        send_byte(8'h11);
        bus.rx_err  = 1'b1;
        bus.rx_done = 1'b1;
        bus.rx_data = 8'h22;
        tick();
        bus.rx_err  = 1'b0;
        bus.rx_done = 1'b0;
        bus.rx_data = 8'h00;
        $display("t=%0t rx_err with byte 22 -> frame_err=%0b", $time, bus.frame_err);
        check("err_frame_err", 32'(bus.frame_err), 32'h1);
        check("err_no_valid", 32'(bus.opp_valid), 32'h0);
        // FSM must be back in IDLE: 04 starts a fresh frame.
        send_frame(8'h04, 8'h00, 8'h00, 8'h09);
        check("err_resync_valid", 32'(bus.opp_valid), 32'h1);
        check("err_resync_ID", 32'(bus.opp_ID), 32'h04);
        check("err_resync_points", 32'(bus.opp_points), 32'h000009);

        // Reset mid-frame.
        send_byte(8'h05);
        send_byte(8'h66);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_opp_ID", 32'(bus.opp_ID), 32'h0);
        check("rst_opp_points", 32'(bus.opp_points), 32'h0);
        check("rst_link_up", 32'(bus.link_up), 32'h0);
        check("rst_frame_err", 32'(bus.frame_err), 32'h0);
        fe_snap = fe_cnt;
        idle(20);
        check("rst_no_late_frame_err", 32'(fe_cnt), 32'(fe_snap));

        // Byte arriving on the same cycle as timeout expiry is kept.
        fe_snap = fe_cnt;
        ov_snap = ov_cnt;
        send_byte(8'h07);
        send_byte(8'h11);
        idle(15);
        send_byte(8'h22);
        check("race_no_frame_err", 32'(bus.frame_err), 32'h0);
        send_byte(8'h33);
        check("race_valid", 32'(bus.opp_valid), 32'h1);
        check("race_ID", 32'(bus.opp_ID), 32'h07);
        check("race_points", 32'(bus.opp_points), 32'h112233);
        tick();
        check("race_fe_count", 32'(fe_cnt), 32'(fe_snap));
        check("race_valid_count", 32'(ov_cnt), 32'(ov_snap + 1));

        // Link timeout: link_up drops exactly LT cycles after opp_valid.
        send_frame(8'h06, 8'h01, 8'h02, 8'h03);
        check("link_valid", 32'(bus.opp_valid), 32'h1);
        check("link_up_set", 32'(bus.link_up), 32'h1);
        idle(LT - 1);
        check("link_up_before_timeout", 32'(bus.link_up), 32'h1);
        tick();
        check("link_down_at_timeout", 32'(bus.link_up), 32'h0);
        check("link_hold_ID", 32'(bus.opp_ID), 32'h06);
        check("link_hold_points", 32'(bus.opp_points), 32'h010203);
        idle(5);
        check("link_stays_down", 32'(bus.link_up), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
